// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU receive and transmit framers.
// Contents: receive FSM state encoding, CRC-16/MODBUS constants,
// broadcast address and the maximum RTU ADU size in bytes.
package modbus_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,  // waiting for a full t3.5 of line silence before arming
        IDLE,       // armed: the next byte starts a frame
        RECEIVE,    // collecting bytes of a frame
        CHECK,      // t1.5 seen: frame ended, waiting out t3.5 before judging it
        HOLD        // accepted frame held for the protocol engine
    } state_t;

    localparam logic [15:0] CRC_INIT          = 16'hFFFF;
    localparam logic [15:0] CRC_POLY          = 16'hA001;  // reflected 0x8005
    localparam logic [7:0]  MODBUS_BCAST_ADDR = 8'h00;
    localparam int          MAX_ADU           = 256;

endpackage

// File: rtl/modbus_rtu_frame_rx_if.sv
// Signal bundle between the frame receiver and its environment.
// slave  : the receiver (takes UART bytes, slave address, read index, ack;
//          drives read data, frame status, error pulses, busy, debug state).
// master : the environment side (UART receiver + protocol engine).
//
// Handshake: i_Rx_DV is a one-cycle strobe qualifying i_Rx_Byte (no back
// pressure). o_Frame_Valid is a level that stays high, with o_Frame_Len,
// o_Broadcast and the buffer contents frozen, until the consumer pulses
// i_Frame_Ack; the frame is released on the clock edge that samples the ack.
interface modbus_rtu_frame_rx_if;
    import modbus_pkg::*;

    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;
    logic [7:0] i_Slave_Addr;
    logic       i_Frame_Ack;
    logic [7:0] i_Rd_Addr;
    logic [7:0] o_Rd_Data;
    logic       o_Frame_Valid;
    logic [8:0] o_Frame_Len;
    logic       o_Broadcast;
    logic       o_Crc_Err;
    logic       o_Frame_Err;
    logic       o_Busy;
    state_t     o_Dbg_State;

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Slave_Addr, i_Frame_Ack, i_Rd_Addr,
        output o_Rd_Data, o_Frame_Valid, o_Frame_Len, o_Broadcast,
               o_Crc_Err, o_Frame_Err, o_Busy, o_Dbg_State
    );

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Slave_Addr, i_Frame_Ack, i_Rd_Addr,
        input  o_Rd_Data, o_Frame_Valid, o_Frame_Len, o_Broadcast,
               o_Crc_Err, o_Frame_Err, o_Busy, o_Dbg_State
    );

endinterface

// File: rtl/modbus_crc16_byte.sv
// Combinational CRC-16/MODBUS byte step: folds one data byte into a running
// CRC (reflected polynomial, LSB first, eight shift/xor steps unrolled).
// Ports: crc_in  - running CRC before the byte
//        data_in - byte to fold in
//        crc_out - running CRC after the byte
module modbus_crc16_byte
    import modbus_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    always_comb begin
        logic [15:0] c;
        c = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame receiver. Delimits frames from the UART byte stream using
// t1.5 (end of frame) and t3.5 (inter-frame) silence, checks length, CRC and
// slave address, and holds an accepted frame in a byte buffer until acked.
// Ports: i_Clock, i_Rst_n (async, active low) and the rx_if bundle
//        (slave modport): byte input strobe, slave address, buffer read port,
//        frame status/ack, CRC/frame error pulses, busy and debug state.
module modbus_rtu_frame_rx
    import modbus_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347,
    parameter int T15_CLKS     = (33 * CLKS_PER_BIT) / 2,  // 1.5 chars x 11 bits
    parameter int T35_CLKS     = (77 * CLKS_PER_BIT) / 2,  // 3.5 chars x 11 bits
    parameter int MAX_FRAME    = MAX_ADU                   // at most 256 (8-bit read index)
)(
    input  logic                  i_Clock,
    input  logic                  i_Rst_n,
    modbus_rtu_frame_rx_if.slave  rx_if
);

    localparam int CW = $clog2(T35_CLKS + 1);
    localparam int PW = $clog2(MAX_FRAME + 1);
    localparam int AW = $clog2(MAX_FRAME);
    localparam logic [CW-1:0] T15_C  = CW'(T15_CLKS);
    localparam logic [CW-1:0] T35_C  = CW'(T35_CLKS);
    localparam logic [PW-1:0] FULL_P = PW'(MAX_FRAME);

    state_t         state;
    logic [CW-1:0]  sil_cnt;
    logic [PW-1:0]  wr_ptr;
    logic [15:0]    crc;
    logic [15:0]    crc_seed;
    logic [15:0]    crc_next;
    logic [7:0]     addr_byte;   // copy of buf[0] so the address check needs no memory read
    logic [7:0]     buf_mem [MAX_FRAME];
    logic           buf_we;
    logic [AW-1:0]  buf_waddr;
    logic [7:0]     rd_data;
    logic           frame_valid;
    logic [8:0]     frame_len;
    logic           broadcast;
    logic           crc_err;
    logic           frame_err;
    logic           t15_hit;
    logic           t35_hit;

    assign t15_hit = (sil_cnt == T15_C);
    assign t35_hit = (sil_cnt == T35_C);

    // The first byte of a frame always starts from the CRC seed, so a stale
    // CRC from an aborted frame never leaks into the next one.
    assign crc_seed = (state == IDLE) ? CRC_INIT : crc;

    modbus_crc16_byte u_crc (
        .crc_in  (crc_seed),
        .data_in (rx_if.i_Rx_Byte),
        .crc_out (crc_next)
    );

    // Writes happen only while collecting a frame; HOLD is write-protected.
    assign buf_we    = rx_if.i_Rx_DV &&
                       ((state == IDLE) || ((state == RECEIVE) && (wr_ptr != FULL_P)));
    assign buf_waddr = (state == IDLE) ? '0 : wr_ptr[AW-1:0];

    // Silence counter: any byte restarts it, otherwise it saturates at t3.5.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sil_cnt <= '0;
        end else if (rx_if.i_Rx_DV) begin
            sil_cnt <= '0;
        end else if (!t35_hit) begin
            sil_cnt <= sil_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (buf_we) begin
            buf_mem[buf_waddr] <= rx_if.i_Rx_Byte;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= buf_mem[rx_if.i_Rd_Addr];
        end
    end

    // Frame FSM. A byte strobe is always examined before a silence threshold,
    // so a byte landing on the threshold cycle suppresses the threshold event.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= WAIT_IDLE;
            wr_ptr      <= '0;
            crc         <= CRC_INIT;
            addr_byte   <= 8'h00;
            frame_valid <= 1'b0;
            frame_len   <= 9'd0;
            broadcast   <= 1'b0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                WAIT_IDLE: begin
                    if (!rx_if.i_Rx_DV && t35_hit) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (rx_if.i_Rx_DV) begin
                        addr_byte <= rx_if.i_Rx_Byte;
                        wr_ptr    <= PW'(1);
                        crc       <= crc_next;
                        state     <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (rx_if.i_Rx_DV) begin
                        if (wr_ptr == FULL_P) begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            crc    <= crc_next;
                        end
                    end else if (t15_hit) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (rx_if.i_Rx_DV) begin
                        // Character after t1.5 but before t3.5: frame is corrupt.
                        frame_err <= 1'b1;
                        state     <= WAIT_IDLE;
                    end else if (t35_hit) begin
                        state <= IDLE;
                        if (wr_ptr < PW'(4)) begin
                            frame_err <= 1'b1;
                        end else if (crc != 16'h0000) begin
                            crc_err <= 1'b1;
                        end else if ((addr_byte == rx_if.i_Slave_Addr) ||
                                     (addr_byte == MODBUS_BCAST_ADDR)) begin
                            frame_valid <= 1'b1;
                            frame_len   <= 9'(wr_ptr);
                            broadcast   <= (addr_byte == MODBUS_BCAST_ADDR);
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (rx_if.i_Frame_Ack) begin
                        frame_valid <= 1'b0;
                        broadcast   <= 1'b0;
                        state       <= WAIT_IDLE;
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    assign rx_if.o_Rd_Data     = rd_data;
    assign rx_if.o_Frame_Valid = frame_valid;
    assign rx_if.o_Frame_Len   = frame_len;
    assign rx_if.o_Broadcast   = broadcast;
    assign rx_if.o_Crc_Err     = crc_err;
    assign rx_if.o_Frame_Err   = frame_err;
    assign rx_if.o_Busy        = (state == RECEIVE) || (state == CHECK);
    assign rx_if.o_Dbg_State   = state;

endmodule
